pheap_sift_ctrl: RTL and testbench

- Per-level sift-down controller for the pipelined heap; it is the driver of a heap level's RAM ports.
- Accepts a sift token (slot index + entry) from the controller of level LEVEL-1.
- Reads the child pair from level LEVEL+1 in bottom mode, compares, writes the winner into its own level in top mode, and forwards the token downward when the entry must keep sinking.
- One instance per level; instances chain through the token handshake.

---
 rtl/pheap_sift_ctrl_pkg.sv | 19 +
 rtl/pheap_entry_min2.sv | 20 ++
 rtl/pheap_sift_ctrl.sv | 149 ++++++++++++++
 tb/tb_pheap_sift_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pheap_sift_ctrl_pkg.sv
// Shared heap types.
//   entry_t  : one heap entry, {valid, key}. A non-valid entry ranks as +infinity.
//   KEY_W    : key width in bits.
//   entry_lt : strict "a ranks before b" comparison under that ordering.
package pheapTypes;

    localparam int KEY_W = 8;

    typedef struct packed {
        logic             valid;
        logic [KEY_W-1:0] key;
    } entry_t;

    // a < b, with a non-valid entry treated as +infinity
    function automatic logic entry_lt(input entry_t a, input entry_t b);
        return a.valid & (~b.valid | (a.key < b.key));
    endfunction

endpackage

// File: rtl/pheap_entry_min2.sv
// Combinational minimum of a child pair.
//   left, right : the two children of one parent slot
//   winner      : the smaller child; on a tie the left child wins
//   side        : 0 = left won, 1 = right won
module pheap_entry_min2
    import pheapTypes::*;
(
    input  entry_t left,
    input  entry_t right,
    output entry_t winner,
    output logic   side
);

    // pick the smaller child; the right child must be strictly smaller to win
    always_comb begin
        side   = entry_lt(right, left);
        winner = side ? right : left;
    end

endmodule

// File: rtl/pheap_sift_ctrl.sv
// Sift-down controller for one level of the pipelined heap.
//   tok_*_i / tok_ready_o : token (slot index + entry) arriving from the level above
//   child_rd_o/raddr_o    : bottom-mode read of the child pair in the level below
//   child_yl_i/yr_i       : child pair data, one cycle after the read
//   own_*                 : top-mode write port of this level's RAM
//   tok_*_o / tok_ready_i : token forwarded to the level below when the entry keeps sinking
//   busy_o                : controller is working on a token
// LAST=1 makes this the bottom level: the entry is written straight away, never forwarded.
module pheap_sift_ctrl
    import pheapTypes::*;
#(
    parameter int LEVEL = 2,
    parameter bit LAST  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tok_valid_i,
    output logic             tok_ready_o,
    input  logic [LEVEL-2:0] tok_idx_i,
    input  entry_t           tok_entry_i,
    output logic             child_rd_o,
    output logic [LEVEL-1:0] child_raddr_o,
    input  entry_t           child_yl_i,
    input  entry_t           child_yr_i,
    output logic             own_top_o,
    output logic             own_wen_o,
    output logic [LEVEL-2:0] own_waddr_o,
    output entry_t           own_wdata_o,
    output logic             tok_valid_o,
    input  logic             tok_ready_i,
    output logic [LEVEL-1:0] tok_idx_o,
    output entry_t           tok_entry_o,
    output logic             busy_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_CMP  = 2'd2;
    localparam logic [1:0] ST_WR   = 2'd3;

    logic [1:0]       state_r;
    logic [1:0]       state_n_s;
    logic [LEVEL-2:0] idx_r;
    entry_t           entry_r;
    entry_t           wdata_r;
    logic             fwd_r;
    logic             side_r;
    logic             first_r;

    entry_t           min_s;
    logic             min_side_s;
    logic             write_s;
    logic             fwd_act_s;

    pheap_entry_min2 u_min2 (
        .left   (child_yl_i),
        .right  (child_yr_i),
        .winner (min_s),
        .side   (min_side_s)
    );

    // next-state selection
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (tok_valid_i) begin
                    state_n_s = LAST ? ST_WR : ST_RD;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_RD:  state_n_s = ST_CMP;
            ST_CMP: state_n_s = ST_WR;
            ST_WR: begin
                // a forwarded token holds WR until the lower level takes it
                if (!fwd_r || tok_ready_i) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_WR;
                end
            end
            default: state_n_s = ST_IDLE;
        endcase
    end

    // state, captured token and registered sift decision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= {(LEVEL-1){1'b0}};
            entry_r <= '0;
            wdata_r <= '0;
            fwd_r   <= 1'b0;
            side_r  <= 1'b0;
            first_r <= 1'b0;
        end else begin
            state_r <= state_n_s;
            // first_r marks the single write cycle on entry to WR
            first_r <= (state_n_s == ST_WR) && (state_r != ST_WR);
            case (state_r)
                ST_IDLE: begin
                    if (tok_valid_i) begin
                        idx_r   <= tok_idx_i;
                        entry_r <= tok_entry_i;
                        wdata_r <= tok_entry_i;
                        fwd_r   <= 1'b0;
                        side_r  <= 1'b0;
                    end else begin
                        idx_r   <= idx_r;
                    end
                end
                ST_CMP: begin
                    // the smaller child moves up only if strictly smaller than the entry
                    if (entry_lt(min_s, entry_r)) begin
                        wdata_r <= min_s;
                        fwd_r   <= 1'b1;
                        side_r  <= min_side_s;
                    end else begin
                        wdata_r <= entry_r;
                        fwd_r   <= 1'b0;
                        side_r  <= 1'b0;
                    end
                end
                default: begin
                    fwd_r <= fwd_r;
                end
            endcase
        end
    end

    // output decode from registered state only; unused fields are held at zero
    always_comb begin
        write_s       = (state_r == ST_WR) && first_r;
        fwd_act_s     = (state_r == ST_WR) && fwd_r;
        tok_ready_o   = (state_r == ST_IDLE);
        busy_o        = (state_r != ST_IDLE);
        child_rd_o    = (state_r == ST_RD);
        child_raddr_o = (state_r == ST_RD) ? {idx_r, 1'b0} : {LEVEL{1'b0}};
        own_top_o     = write_s;
        own_wen_o     = write_s;
        own_waddr_o   = write_s ? idx_r : {(LEVEL-1){1'b0}};
        own_wdata_o   = write_s ? wdata_r : '0;
        tok_valid_o   = fwd_act_s;
        tok_idx_o     = fwd_act_s ? {idx_r, side_r} : {LEVEL{1'b0}};
        tok_entry_o   = fwd_act_s ? entry_r : '0;
    end

endmodule

// File: tb/tb_pheap_sift_ctrl.sv
module tb_pheap_sift_ctrl;
    import pheapTypes::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // level-3 controller with a child level below it
    logic       tok_valid_i, tok_ready_o, child_rd_o, own_top_o, own_wen_o;
    logic       tok_valid_o, tok_ready_i, busy_o;
    logic [1:0] tok_idx_i, own_waddr_o;
    logic [2:0] child_raddr_o, tok_idx_o;
    entry_t     tok_entry_i, child_yl_i, child_yr_i, own_wdata_o, tok_entry_o;

    // level-3 controller configured as the bottom level
    logic       l_tok_valid_i, l_tok_ready_o, l_child_rd_o, l_own_top_o, l_own_wen_o;
    logic       l_tok_valid_o, l_tok_ready_i, l_busy_o;
    logic [1:0] l_tok_idx_i, l_own_waddr_o;
    logic [2:0] l_child_raddr_o, l_tok_idx_o;
    entry_t     l_tok_entry_i, l_child_yl_i, l_child_yr_i, l_own_wdata_o, l_tok_entry_o;

    pheap_sift_ctrl #(.LEVEL(3), .LAST(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .tok_valid_i(tok_valid_i), .tok_ready_o(tok_ready_o),
        .tok_idx_i(tok_idx_i), .tok_entry_i(tok_entry_i),
        .child_rd_o(child_rd_o), .child_raddr_o(child_raddr_o),
        .child_yl_i(child_yl_i), .child_yr_i(child_yr_i),
        .own_top_o(own_top_o), .own_wen_o(own_wen_o),
        .own_waddr_o(own_waddr_o), .own_wdata_o(own_wdata_o),
        .tok_valid_o(tok_valid_o), .tok_ready_i(tok_ready_i),
        .tok_idx_o(tok_idx_o), .tok_entry_o(tok_entry_o),
        .busy_o(busy_o)
    );

    pheap_sift_ctrl #(.LEVEL(3), .LAST(1'b1)) dut_last (
        .clk(clk), .rst_n(rst_n),
        .tok_valid_i(l_tok_valid_i), .tok_ready_o(l_tok_ready_o),
        .tok_idx_i(l_tok_idx_i), .tok_entry_i(l_tok_entry_i),
        .child_rd_o(l_child_rd_o), .child_raddr_o(l_child_raddr_o),
        .child_yl_i(l_child_yl_i), .child_yr_i(l_child_yr_i),
        .own_top_o(l_own_top_o), .own_wen_o(l_own_wen_o),
        .own_waddr_o(l_own_waddr_o), .own_wdata_o(l_own_wdata_o),
        .tok_valid_o(l_tok_valid_o), .tok_ready_i(l_tok_ready_i),
        .tok_idx_o(l_tok_idx_o), .tok_entry_o(l_tok_entry_o),
        .busy_o(l_busy_o)
    );

    // child level RAM: bottom-mode read returns addr and addr+1 one cycle later
    entry_t cmem [8];
    always @(posedge clk) begin
        if (child_rd_o) begin
            child_yl_i <= cmem[child_raddr_o];
            child_yr_i <= cmem[3'(child_raddr_o + 3'd1)];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] idx;
        entry_t     e, l, r;
        int         bp;
        entry_t     exp_w;
        bit         exp_fwd;
        logic [2:0] exp_fidx;
    } vec_t;

    function automatic entry_t mk(input bit v, input int k);
        entry_t x;
        x.valid = v;
        x.key   = k[7:0];
        return x;
    endfunction

    function automatic vec_t mkv(input logic [1:0] idx, input entry_t e, input entry_t l,
                                 input entry_t r, input int bp, input entry_t w,
                                 input bit f, input logic [2:0] fi);
        vec_t v;
        v.idx = idx; v.e = e; v.l = l; v.r = r; v.bp = bp;
        v.exp_w = w; v.exp_fwd = f; v.exp_fidx = fi;
        return v;
    endfunction

    // reference: invalid entries rank as a key larger than any real key
    function automatic int eff(input entry_t x);
        return x.valid ? int'(x.key) : 1000;
    endfunction

    function automatic vec_t model(input logic [1:0] idx, input entry_t e, input entry_t l,
                                   input entry_t r, input int bp);
        vec_t v;
        bit   right_wins;
        int   mkey;
        right_wins = eff(r) < eff(l);
        mkey = right_wins ? eff(r) : eff(l);
        v = mkv(idx, e, l, r, bp, e, 1'b0, 3'd0);
        if (mkey < eff(e)) begin
            v.exp_w    = right_wins ? r : l;
            v.exp_fwd  = 1'b1;
            v.exp_fidx = 3'(2 * int'(idx) + (right_wins ? 1 : 0));
        end
        return v;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, ".ready"},  32'(tok_ready_o), 32'd1);
        check({tag, ".busy"},   32'(busy_o), 32'd0);
        check({tag, ".rd"},     32'({child_rd_o, child_raddr_o}), 32'd0);
        check({tag, ".own"},    32'({own_top_o, own_wen_o, own_waddr_o, own_wdata_o}), 32'd0);
        check({tag, ".tokout"}, 32'({tok_valid_o, tok_idx_o, tok_entry_o}), 32'd0);
    endtask

    task automatic apply(input vec_t v, input string tag);
        int g = 0, nrd = 0, ntop = 0, nwr = 0, wk = 0, nv = 0, nxfer = 0, fk = 0, rk = 0;
        bit unstable = 1'b0;
        logic [1:0] wa = 2'd0;
        logic [2:0] fi = 3'd0;
        entry_t wd = '0, fe = '0;
        cmem[{v.idx, 1'b0}] = v.l;
        cmem[{v.idx, 1'b1}] = v.r;
        while (!tok_ready_o && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        check({tag, ".ready_wait"}, 32'(tok_ready_o), 32'd1);
        tok_idx_i = v.idx; tok_entry_i = v.e; tok_valid_i = 1'b1;
        @(posedge clk); #1;
        tok_valid_i = 1'b0; tok_idx_i = 2'd0; tok_entry_i = '0;
        check({tag, ".raddr"}, 32'({child_rd_o, child_raddr_o}), 32'({1'b1, v.idx, 1'b0}));
        for (int k = 1; k <= 30; k++) begin
            if (child_rd_o) nrd++;
            if (own_top_o) ntop++;
            if (own_wen_o) begin
                nwr++; wk = k; wa = own_waddr_o; wd = own_wdata_o;
            end
            if (tok_valid_o) begin
                if (nv == 0) begin
                    fi = tok_idx_o; fe = tok_entry_o; fk = k;
                end else if (tok_idx_o !== fi || tok_entry_o !== fe) begin
                    unstable = 1'b1;
                end
                tok_ready_i = (nv >= v.bp);
                if (tok_ready_i) nxfer++;
                nv++;
            end else begin
                tok_ready_i = 1'b0;
            end
            if (tok_ready_o) begin
                rk = k;
                break;
            end
            @(posedge clk); #1;
        end
        tok_ready_i = 1'b0;
        check({tag, ".nrd"},   32'(nrd), 32'd1);
        check({tag, ".nwr"},   32'(nwr), 32'd1);
        check({tag, ".ntop"},  32'(ntop), 32'd1);
        check({tag, ".wcyc"},  32'(wk), 32'd3);
        check({tag, ".waddr"}, 32'(wa), 32'(v.idx));
        check({tag, ".wdata"}, 32'(wd), 32'(v.exp_w));
        check({tag, ".fwd"},   32'(nv > 0), 32'(v.exp_fwd));
        check({tag, ".rdy_cyc"}, 32'(rk), v.exp_fwd ? 32'(4 + v.bp) : 32'd4);
        if (v.exp_fwd) begin
            check({tag, ".fidx"},   32'(fi), 32'(v.exp_fidx));
            check({tag, ".fentry"}, 32'(fe), 32'(v.e));
            check({tag, ".fcyc"},   32'(fk), 32'd3);
            check({tag, ".stable"}, 32'(unstable), 32'd0);
            check({tag, ".nvalid"}, 32'(nv), 32'(v.bp + 1));
            check({tag, ".nxfer"},  32'(nxfer), 32'd1);
        end
    endtask

    vec_t tbl [7];

    initial begin
        int nwr_rst;
        int nrd_last;
        int nfwd_last;
        tok_valid_i = 1'b0; tok_idx_i = 2'd0; tok_entry_i = '0; tok_ready_i = 1'b0;
        l_tok_valid_i = 1'b0; l_tok_idx_i = 2'd0; l_tok_entry_i = '0; l_tok_ready_i = 1'b1;
        l_child_yl_i = '0; l_child_yr_i = '0;
        for (int i = 0; i < 8; i++) cmem[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        check("reset.last_ready", 32'(l_tok_ready_o), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        tbl[0] = mkv(2'd1, mk(1, 5),  mk(1, 7), mk(1, 9), 0, mk(1, 5),  1'b0, 3'd0);
        tbl[1] = mkv(2'd2, mk(1, 20), mk(1, 8), mk(1, 3), 0, mk(1, 3),  1'b1, 3'd5);
        tbl[2] = mkv(2'd1, mk(1, 10), mk(1, 4), mk(1, 4), 0, mk(1, 4),  1'b1, 3'd2);
        tbl[3] = mkv(2'd0, mk(1, 4),  mk(1, 4), mk(1, 6), 0, mk(1, 4),  1'b0, 3'd0);
        tbl[4] = mkv(2'd3, mk(1, 50), mk(0, 0), mk(0, 0), 0, mk(1, 50), 1'b0, 3'd0);
        tbl[5] = mkv(2'd2, mk(1, 20), mk(1, 8), mk(1, 3), 3, mk(1, 3),  1'b1, 3'd5);
        tbl[6] = mkv(2'd3, mk(1, 12), mk(1, 2), mk(0, 0), 0, mk(1, 2),  1'b1, 3'd6);
        for (int i = 0; i < 7; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // reset in the middle of RD: token dropped, no write afterwards
        cmem[2] = mk(1, 1); cmem[3] = mk(1, 2);
        tok_idx_i = 2'd1; tok_entry_i = mk(1, 30); tok_valid_i = 1'b1;
        @(posedge clk); #1;
        tok_valid_i = 1'b0;
        check("midrst.in_rd", 32'(child_rd_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle("midrst");
        nwr_rst = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (own_wen_o) nwr_rst++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (own_wen_o) nwr_rst++;
        end
        check("midrst.no_write", 32'(nwr_rst), 32'd0);
        check_idle("midrst.after");

        // bottom level: write one cycle after accept, no child read, no forward
        nrd_last = 0; nfwd_last = 0;
        l_tok_idx_i = 2'd3; l_tok_entry_i = mk(1, 9); l_tok_valid_i = 1'b1;
        if (l_child_rd_o) nrd_last++;
        @(posedge clk); #1;
        l_tok_valid_i = 1'b0; l_tok_idx_i = 2'd0; l_tok_entry_i = '0;
        check("last.write", 32'({l_own_top_o, l_own_wen_o, l_own_waddr_o}), 32'({1'b1, 1'b1, 2'd3}));
        check("last.wdata", 32'(l_own_wdata_o), 32'(mk(1, 9)));
        check("last.busy",  32'({l_busy_o, l_tok_ready_o}), 32'({1'b1, 1'b0}));
        for (int k = 0; k < 4; k++) begin
            if (l_child_rd_o) nrd_last++;
            if (l_tok_valid_o) nfwd_last++;
            @(posedge clk); #1;
            if (k == 0) begin
                check("last.one_pulse", 32'(l_own_wen_o), 32'd0);
                check("last.ready_back", 32'(l_tok_ready_o), 32'd1);
            end
        end
        check("last.no_rd",  32'(nrd_last), 32'd0);
        check("last.no_fwd", 32'(nfwd_last), 32'd0);

        // randomized tokens against the reference model
        for (int n = 0; n < 40; n++) begin
            entry_t e, l, r;
            e = mk($urandom_range(3, 0) != 0, int'($urandom_range(15, 0)));
            l = mk($urandom_range(3, 0) != 0, int'($urandom_range(15, 0)));
            r = mk($urandom_range(3, 0) != 0, int'($urandom_range(15, 0)));
            apply(model(2'($urandom_range(3, 0)), e, l, r, int'($urandom_range(2, 0))),
                  $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
